// File: rtl/hamming74_pkg.sv
// Shared types and coding functions for the serial Hamming(7,4) link.
// The downstream decoder's syndrome equations rely on the same bit placement as hamming74_encode.
package hamming74_pkg;

    localparam int DATA_W = 4;
    localparam int CODE_W = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_e;

    function automatic logic parity3(input logic a, input logic b, input logic c);
        return a ^ b ^ c;
    endfunction

    // Data sits in c0,c1,c2,c4; parity bits sit in c3,c5,c6.
    function automatic logic [CODE_W-1:0] hamming74_encode(input logic [DATA_W-1:0] d);
        logic [CODE_W-1:0] c;
        c[0] = d[0];
        c[1] = d[1];
        c[2] = d[2];
        c[4] = d[3];
        c[3] = parity3(c[2], c[1], c[0]);
        c[5] = parity3(c[4], c[1], c[0]);
        c[6] = parity3(c[4], c[2], c[0]);
        return c;
    endfunction

    // A shift by 7 pushes the mask out of the word, so idx=7 leaves the codeword untouched.
    function automatic logic [CODE_W-1:0] hamming74_inject(input logic [CODE_W-1:0] c,
                                                           input logic              en,
                                                           input logic [2:0]        idx);
        logic [CODE_W-1:0] mask;
        mask = {6'd0, en} << idx;
        return c ^ mask;
    endfunction

endpackage

// File: rtl/hamming74_serial_encoder.sv
// Serial Hamming(7,4) encoder: nibble handshake in, LSB-first codeword out with a guard gap.
// A one-entry holding buffer lets the next nibble wait while the current frame shifts, so frames go out back-to-back.
module hamming74_serial_encoder
    import hamming74_pkg::*;
#(
    parameter int GAP_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_err_en,
    input  logic [2:0]        in_err_idx,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              ser_out,
    output logic              ser_valid,
    output logic              frame_start,
    output logic              busy
);

    localparam logic       HAS_GAP_C  = (GAP_CYCLES != 32'sd0);
    localparam logic [2:0] GAP_LAST_C = 3'(GAP_CYCLES - 32'sd1);
    localparam logic [2:0] BIT_LAST_C = 3'd6;

    state_e            state_r, state_n_s;
    logic [CODE_W-1:0] shreg_r, shreg_n_s;
    logic [CODE_W-1:0] buf_code_r, buf_code_n_s;
    logic              buf_full_r, buf_full_n_s;
    logic [2:0]        bit_cnt_r, bit_cnt_n_s;
    logic [2:0]        gap_cnt_r, gap_cnt_n_s;
    logic [2:0]        bit_nxt_s;
    logic [CODE_W-1:0] in_code_s, load_code_s;
    logic              accept_s, direct_s, load_s, drain_s;
    logic              ser_out_r, ser_out_n_s;
    logic              ser_valid_r, ser_valid_n_s;
    logic              frame_start_r, frame_start_n_s;
    logic              busy_r, busy_n_s;
    logic              in_ready_r, in_ready_n_s;

    // Decide whether a codeword enters the shifter this edge, and from where.
    always_comb begin
        in_code_s   = hamming74_inject(hamming74_encode(in_data), in_err_en, in_err_idx);
        accept_s    = in_valid & in_ready_r;
        direct_s    = 1'b0;
        load_s      = 1'b0;
        drain_s     = 1'b0;
        load_code_s = buf_code_r;
        case (state_r)
            IDLE: begin
                if (ena && buf_full_r) begin
                    load_s  = 1'b1;
                    drain_s = 1'b1;
                end else if (ena && accept_s) begin
                    load_s      = 1'b1;
                    direct_s    = 1'b1;
                    load_code_s = in_code_s;
                end else begin
                    load_s = 1'b0;
                end
            end
            SHIFT: begin
                if (ena && (bit_cnt_r == BIT_LAST_C) && !HAS_GAP_C && buf_full_r) begin
                    load_s  = 1'b1;
                    drain_s = 1'b1;
                end else begin
                    load_s = 1'b0;
                end
            end
            GAP: begin
                if (ena && (gap_cnt_r == GAP_LAST_C) && buf_full_r) begin
                    load_s  = 1'b1;
                    drain_s = 1'b1;
                end else begin
                    load_s = 1'b0;
                end
            end
            default: begin
                load_s = 1'b0;
            end
        endcase
    end

    // Holding buffer: a write wins over a drain on the same edge, so neither nibble is lost.
    always_comb begin
        buf_full_n_s = buf_full_r;
        buf_code_n_s = buf_code_r;
        if (accept_s && !direct_s) begin
            buf_full_n_s = 1'b1;
            buf_code_n_s = in_code_s;
        end else if (drain_s) begin
            buf_full_n_s = 1'b0;
        end else begin
            buf_full_n_s = buf_full_r;
        end
    end

    // Next state, counters and the values the output registers will present next cycle.
    always_comb begin
        state_n_s       = state_r;
        shreg_n_s       = shreg_r;
        bit_cnt_n_s     = bit_cnt_r;
        gap_cnt_n_s     = gap_cnt_r;
        bit_nxt_s       = bit_cnt_r + 3'd1;
        ser_out_n_s     = 1'b0;
        ser_valid_n_s   = 1'b0;
        frame_start_n_s = 1'b0;
        if (load_s) begin
            state_n_s       = SHIFT;
            shreg_n_s       = load_code_s;
            bit_cnt_n_s     = 3'd0;
            gap_cnt_n_s     = 3'd0;
            ser_out_n_s     = load_code_s[0];
            ser_valid_n_s   = 1'b1;
            frame_start_n_s = 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    state_n_s = IDLE;
                end
                SHIFT: begin
                    if (!ena) begin
                        state_n_s = SHIFT;
                    end else if (bit_cnt_r != BIT_LAST_C) begin
                        bit_cnt_n_s   = bit_nxt_s;
                        ser_out_n_s   = shreg_r[bit_nxt_s];
                        ser_valid_n_s = 1'b1;
                    end else if (HAS_GAP_C) begin
                        state_n_s   = GAP;
                        gap_cnt_n_s = 3'd0;
                    end else begin
                        state_n_s = IDLE;
                    end
                end
                GAP: begin
                    if (!ena) begin
                        state_n_s = GAP;
                    end else if (gap_cnt_r == GAP_LAST_C) begin
                        state_n_s = IDLE;
                    end else begin
                        gap_cnt_n_s = gap_cnt_r + 3'd1;
                    end
                end
                default: begin
                    state_n_s = IDLE;
                end
            endcase
        end
        busy_n_s     = (state_n_s != IDLE) | buf_full_n_s;
        in_ready_n_s = ~buf_full_n_s;
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= IDLE;
            shreg_r       <= 7'd0;
            buf_code_r    <= 7'd0;
            buf_full_r    <= 1'b0;
            bit_cnt_r     <= 3'd0;
            gap_cnt_r     <= 3'd0;
            ser_out_r     <= 1'b0;
            ser_valid_r   <= 1'b0;
            frame_start_r <= 1'b0;
            busy_r        <= 1'b0;
            in_ready_r    <= 1'b1;
        end else begin
            state_r       <= state_n_s;
            shreg_r       <= shreg_n_s;
            buf_code_r    <= buf_code_n_s;
            buf_full_r    <= buf_full_n_s;
            bit_cnt_r     <= bit_cnt_n_s;
            gap_cnt_r     <= gap_cnt_n_s;
            ser_out_r     <= ser_out_n_s;
            ser_valid_r   <= ser_valid_n_s;
            frame_start_r <= frame_start_n_s;
            busy_r        <= busy_n_s;
            in_ready_r    <= in_ready_n_s;
        end
    end

    assign in_ready    = in_ready_r;
    assign ser_out     = ser_out_r;
    assign ser_valid   = ser_valid_r;
    assign frame_start = frame_start_r;
    assign busy        = busy_r;

endmodule

// File: tb/tb_hamming74_serial_encoder.sv
// Self-checking bench for hamming74_serial_encoder: directed scenarios plus a randomized stream
// scored against a frame-level reference model; a second instance covers the zero-gap configuration.
module tb_hamming74_serial_encoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ena = 1'b1;
    logic [3:0] in_data = 4'd0;
    logic       in_err_en = 1'b0;
    logic [2:0] in_err_idx = 3'd7;
    logic       in_valid = 1'b0;
    logic       in_ready, ser_out, ser_valid, frame_start, busy;

    logic [3:0] d0_in_data = 4'd0;
    logic       d0_in_valid = 1'b0;
    logic       d0_err_en = 1'b0;
    logic [2:0] d0_err_idx = 3'd7;
    logic       d0_in_ready, d0_ser_out, d0_ser_valid, d0_frame_start, d0_busy;

    int         n_checks = 0;
    int         n_fail = 0;
    int         cycle = 0;
    logic [6:0] exp_q[$];
    int         fs_cyc[$];
    logic [6:0] cur_frame = 7'd0;
    logic [6:0] last_frame = 7'd0;
    int         bit_cnt = 0;
    bit         in_frame = 1'b0;

    hamming74_serial_encoder #(.GAP_CYCLES(1)) u_dut (
        .clk(clk), .rst(rst), .ena(ena), .in_data(in_data), .in_err_en(in_err_en),
        .in_err_idx(in_err_idx), .in_valid(in_valid), .in_ready(in_ready), .ser_out(ser_out),
        .ser_valid(ser_valid), .frame_start(frame_start), .busy(busy)
    );

    hamming74_serial_encoder #(.GAP_CYCLES(0)) u_dut0 (
        .clk(clk), .rst(rst), .ena(ena), .in_data(d0_in_data), .in_err_en(d0_err_en),
        .in_err_idx(d0_err_idx), .in_valid(d0_in_valid), .in_ready(d0_in_ready), .ser_out(d0_ser_out),
        .ser_valid(d0_ser_valid), .frame_start(d0_frame_start), .busy(d0_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Reference codeword from the parity rules, using modulo-2 sums.
    function automatic logic [6:0] tb_code(input logic [3:0] d, input logic en, input logic [2:0] idx);
        int b[7];
        logic [6:0] c;
        b[0] = int'(d[0]);
        b[1] = int'(d[1]);
        b[2] = int'(d[2]);
        b[4] = int'(d[3]);
        b[3] = (b[0] + b[1] + b[2]) % 2;
        b[5] = (b[4] + b[1] + b[0]) % 2;
        b[6] = (b[4] + b[2] + b[0]) % 2;
        for (int i = 0; i < 7; i++) c[i] = (b[i] != 0);
        if (en && (int'(idx) < 7)) c[idx] = ~c[idx];
        return c;
    endfunction

    // Single-error correction by search: find the flip (or none) that yields a valid codeword.
    function automatic logic [3:0] tb_decode(input logic [6:0] w);
        logic [6:0] t;
        logic [3:0] d;
        for (int j = -1; j < 7; j++) begin
            t = w;
            if (j >= 0) t[j] = ~t[j];
            d = {t[4], t[2], t[1], t[0]};
            if (tb_code(d, 1'b0, 3'd7) == t) return d;
        end
        return 4'd0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cycle);
        end
    endtask

    // One clock: score the handshake before the edge, then observe the outputs 1 time unit after it.
    task automatic step();
        logic acc, ena_was, rst_was;
        acc     = in_valid && (in_ready === 1'b1) && !rst;
        ena_was = ena;
        rst_was = rst;
        if (acc) exp_q.push_back(tb_code(in_data, in_err_en, in_err_idx));
        @(posedge clk);
        #1;
        cycle++;
        if (rst_was) begin
            exp_q.delete();
            in_frame = 1'b0;
            bit_cnt  = 0;
        end else if (ser_valid) begin
            check("valid_needs_ena", ena_was, 1);
            if (frame_start) begin
                check("frame_restart", in_frame, 0);
                in_frame = 1'b1;
                bit_cnt  = 0;
                fs_cyc.push_back(cycle);
            end else begin
                check("bit_in_frame", in_frame, 1);
            end
            if (in_frame) begin
                cur_frame[bit_cnt] = ser_out;
                bit_cnt++;
                if (bit_cnt == 7) begin
                    in_frame   = 1'b0;
                    last_frame = cur_frame;
                    check("frame_expected", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) check("frame_value", cur_frame, exp_q.pop_front());
                end
            end
        end else begin
            check("idle_outputs", {ser_out, frame_start}, 0);
        end
    endtask

    task automatic send(input logic [3:0] d, input logic en, input logic [2:0] idx, input bit keep);
        logic got;
        got        = 1'b0;
        in_data    = d;
        in_err_en  = en;
        in_err_idx = idx;
        in_valid   = 1'b1;
        for (int i = 0; i < 50 && !got; i++) begin
            got = in_ready;
            step();
        end
        check("accept_timeout", got, 1);
        if (!keep) in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        ena = 1'b1;
        for (int i = 0; i < 100 && (busy || ser_valid); i++) step();
        check("idle_timeout", busy | ser_valid, 0);
        check("all_frames_out", exp_q.size(), 0);
    endtask

    initial begin
        logic [6:0] w;
        logic [15:0] v_sv, v_fs;
        logic [6:0] f0, f1;
        int n_res;

        // Reset
        step();
        step();
        rst = 1'b0;
        check("rst_ser_out", ser_out, 0);
        check("rst_ser_valid", ser_valid, 0);
        check("rst_frame_start", frame_start, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 1);

        // Single nibble 1011 with exact bit timing and gap
        w = 7'b0110011;
        send(4'hB, 1'b0, 3'd7, 1'b0);
        check("t1_fs", frame_start, 1);
        for (int i = 0; i < 7; i++) begin
            if (i > 0) begin
                step();
                check("t1_fs_low", frame_start, 0);
            end
            check("t1_bit", ser_out, w[i]);
            check("t1_sv", ser_valid, 1);
        end
        step();
        check("t1_gap_sv", ser_valid, 0);
        check("t1_gap_busy", busy, 1);
        step();
        check("t1_busy_fall", busy, 0);

        // Back-to-back stream with in_valid held high
        fs_cyc.delete();
        send(4'h0, 1'b0, 3'd7, 1'b1);
        send(4'hF, 1'b0, 3'd7, 1'b1);
        check("t2_ready_low", in_ready, 0);
        send(4'hA, 1'b0, 3'd7, 1'b0);
        check("t2_ready_low2", in_ready, 0);
        wait_idle();
        check("t2_last_frame", last_frame, 7'h5A);
        check("t2_frames", fs_cyc.size(), 3);
        if (fs_cyc.size() == 3) begin
            check("t2_period1", fs_cyc[1] - fs_cyc[0], 8);
            check("t2_period2", fs_cyc[2] - fs_cyc[1], 8);
        end

        // Error injection
        send(4'hB, 1'b1, 3'd4, 1'b0);
        wait_idle();
        check("t3_err4", last_frame, 7'b0100011);
        check("t3_decoded", tb_decode(last_frame), 4'hB);
        send(4'hB, 1'b1, 3'd7, 1'b0);
        wait_idle();
        check("t3_idx7", last_frame, 7'b0110011);

        // Enable stall after bit 2
        send(4'hF, 1'b0, 3'd7, 1'b0);
        step();
        step();
        check("t4_bit2_sv", ser_valid, 1);
        ena = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t4_stall_sv", ser_valid, 0);
        end
        ena = 1'b1;
        wait_idle();
        check("t4_frame", last_frame, 7'h7F);

        // Reset during bit 4 with a nibble buffered
        send(4'h5, 1'b0, 3'd7, 1'b0);
        send(4'h9, 1'b0, 3'd7, 1'b0);
        check("t5_buf_full", in_ready, 0);
        step();
        step();
        step();
        check("t5_at_bit4", ser_valid, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t5_ser_out", ser_out, 0);
        check("t5_ser_valid", ser_valid, 0);
        check("t5_frame_start", frame_start, 0);
        check("t5_busy", busy, 0);
        check("t5_in_ready", in_ready, 1);
        n_res = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (ser_valid) n_res++;
        end
        check("t5_no_residual", n_res, 0);

        // Randomized stream with random enable gaps and error injection
        for (int i = 0; i < 400; i++) begin
            in_valid   = ($urandom_range(0, 2) != 0);
            in_data    = 4'($urandom);
            in_err_en  = ($urandom_range(0, 3) == 0);
            in_err_idx = 3'($urandom);
            ena        = ($urandom_range(0, 4) != 0);
            step();
        end
        in_valid = 1'b0;
        wait_idle();

        // Zero-gap instance: two nibbles give 14 contiguous valid cycles
        v_sv = 16'd0;
        v_fs = 16'd0;
        f0   = 7'd0;
        f1   = 7'd0;
        check("t6_ready", d0_in_ready, 1);
        d0_in_data  = 4'h3;
        d0_in_valid = 1'b1;
        step();
        d0_in_data = 4'hC;
        for (int i = 0; i < 16; i++) begin
            v_sv[i] = d0_ser_valid;
            v_fs[i] = d0_frame_start;
            if (i < 7) f0[i] = d0_ser_out;
            else if (i < 14) f1[i-7] = d0_ser_out;
            step();
            if (i == 0) d0_in_valid = 1'b0;
        end
        check("t6_valid_run", v_sv, 16'h3FFF);
        check("t6_frame_starts", v_fs, 16'h0081);
        check("t6_frame0", f0, tb_code(4'h3, 1'b0, 3'd7));
        check("t6_frame1", f1, tb_code(4'hC, 1'b0, 3'd7));
        check("t6_idle", d0_busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hamming74_serial_encoder.md
# hamming74_serial_encoder

Upstream stage of the serial Hamming(7,4) link: accepts 4-bit nibbles over a valid/ready handshake, computes the 7-bit codeword and shifts it out one bit per enabled clock, LSB (codeword bit 0) first, followed by a guard gap. Frame timing matches the downstream serial decoder, which samples 7 bits then spends one slot decoding. A one-entry holding buffer lets the next nibble be accepted while the current frame shifts, so frames go out back-to-back. An optional per-nibble single-bit error injection supports link and decoder verification.

## Interface
- GAP_CYCLES, 1, idle cycles after each 7-bit frame (legal 0..7); 1 matches the decoder's 8-slot frame
- clk  in  1  single clock, rising edge
- rst  in  1  reset, synchronous, active-high
- ena  in  1  shift enable; low freezes the shifter, bit counter and gap counter
- in_data  in  4  nibble to encode, d[3:0]
- in_err_en  in  1  inject one bit error into this nibble's codeword
- in_err_idx  in  3  codeword bit to flip (0..6; 7 = no flip)
- in_valid  in  1  in_data/in_err_* valid
- in_ready  out  1  buffer can accept; = !buf_full, no combinational path from in_valid
- ser_out  out  1  serial codeword bit
- ser_valid  out  1  ser_out carries a codeword bit this cycle
- frame_start  out  1  high with codeword bit 0
- busy  out  1  state != IDLE or buffer full

## Operation
- Codeword c[6:0]: c0=d0, c1=d1, c2=d2, c4=d3, c3=c2^c1^c0, c5=c4^c1^c0, c6=c4^c2^c0. If in_err_en and in_err_idx<7, c[in_err_idx] is inverted.
- Accept on a rising edge with in_valid && in_ready. If state is IDLE, buffer empty and ena=1, the codeword loads the shifter directly; otherwise it goes into the holding buffer.
- FSM:
  - IDLE: load from buffer (or direct) -> SHIFT, bit counter = 0.
  - SHIFT: one bit per ena cycle, c0..c6. After bit 6: GAP if GAP_CYCLES>0; else load the next codeword (buffer -> SHIFT) or go to IDLE.
  - GAP: count GAP_CYCLES ena cycles. On the last one, load the next codeword -> SHIFT, else -> IDLE.
- When the buffer drains into the shifter on the same edge that a new nibble is accepted, the new nibble is written to the buffer. No data loss, no double-load.
- ena low: ser_valid=0, frame_start=0, state and counters hold. Handshake into the buffer still works; a direct load is not performed.
- Outputs are registered. ser_out=0 whenever ser_valid=0.

## Timing
- Reset (synchronous): next edge sets state=IDLE, buffer empty, counters 0, ser_out=0, ser_valid=0, frame_start=0, busy=0, in_ready=1. A frame in flight is abandoned and the buffered nibble is dropped.
- Latency: direct load at edge k; c0 is presented in the cycle after edge k, with ser_valid=frame_start=1. c6 is presented in the cycle after edge k+6.
- Frame period: 7+GAP_CYCLES enabled cycles. Sustained throughput is one nibble per period with in_valid held high.
- in_ready falls in the cycle after the buffer fills. It rises in the cycle after the buffer drains into the shifter, unless that same edge accepts a new nibble.
- An ena gap mid-frame stretches the frame. The bit order is never altered.

## Structure
- Package hamming74_pkg:
  - DATA_W=4, CODE_W=7
  - state enum {IDLE, SHIFT, GAP}
  - function hamming74_encode(d[3:0]) returning c[6:0]
- The decoder-side syndrome equations stay consistent with this function.
- No sub-module; the encoder is the package function and the block is a single FSM plus datapath.

## Test plan
- Reset, then one nibble 4'b1011 with ena=1, GAP_CYCLES=1 -> serial bits 1,1,0,0,1,1,0 (c=7'b0110011); frame_start on the first bit; ser_valid high for 7 cycles then low for 1; busy then falls.
- Back-to-back stream 4'h0, 4'hF, 4'hA with in_valid held high -> three frames: 7'h00, 7'h7F, 7'h5A (1010 -> c0..c6 = 0,1,0,1,1,0,1). Exactly one gap cycle between frames; in_ready toggles as the buffer fills and drains.
- 4'b1011 with in_err_en=1, in_err_idx=4 -> 7'b0100011 on the wire. Fed to the downstream decoder, this gives decoded 4'b1011 after correction. in_err_idx=7 -> no flip.
- ena deasserted for 3 cycles after bit 2 of 4'hF -> ser_valid low for those 3 cycles, then bits 3..6 resume; total bit sequence unchanged.
- rst pulsed during bit 4 with a nibble buffered -> the next cycle has all outputs at reset values and in_ready=1; no remaining bits are emitted.
- GAP_CYCLES=0, two nibbles -> 14 consecutive ser_valid cycles with frame_start on cycles 1 and 8.
